// File: rtl/ex_stage.sv
// Execute stage: ID/EX pipeline register, forwarding muxes, ALU and branch/jump resolution.
// Everything downstream of the ID/EX register is combinational.
module ex_stage #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall_i,
    input  logic            flush_i,
    input  logic            id_valid,
    input  logic [2:0]      id_alu_control,
    input  logic            id_alu_src,
    input  logic [XLEN-1:0] id_rd1,
    input  logic [XLEN-1:0] id_rd2,
    input  logic [XLEN-1:0] id_imm_ext,
    input  logic [XLEN-1:0] id_pc,
    input  logic [XLEN-1:0] id_pc_plus4,
    input  logic [4:0]      id_rs1,
    input  logic [4:0]      id_rs2,
    input  logic [4:0]      id_rd,
    input  logic            id_reg_write,
    input  logic            id_mem_write,
    input  logic            id_branch,
    input  logic            id_jump,
    input  logic [1:0]      id_result_src,
    input  logic [1:0]      forward_a,
    input  logic [1:0]      forward_b,
    input  logic [XLEN-1:0] mem_alu_result,
    input  logic [XLEN-1:0] wb_result,
    output logic            ex_valid,
    output logic [XLEN-1:0] ex_alu_result,
    output logic [XLEN-1:0] ex_write_data,
    output logic            ex_zero,
    output logic [4:0]      ex_rs1,
    output logic [4:0]      ex_rs2,
    output logic [4:0]      ex_rd,
    output logic            ex_reg_write,
    output logic            ex_mem_write,
    output logic [1:0]      ex_result_src,
    output logic            ex_pc_src,
    output logic [XLEN-1:0] ex_pc_target,
    output logic [XLEN-1:0] ex_pc_plus4
);

    localparam int unsigned REG_IDX_W = 5;

    typedef struct packed {
        logic                 valid;
        logic [2:0]           alu_control;
        logic                 alu_src;
        logic [XLEN-1:0]      rd1;
        logic [XLEN-1:0]      rd2;
        logic [XLEN-1:0]      imm_ext;
        logic [XLEN-1:0]      pc;
        logic [XLEN-1:0]      pc_plus4;
        logic [REG_IDX_W-1:0] rs1;
        logic [REG_IDX_W-1:0] rs2;
        logic [REG_IDX_W-1:0] rd;
        logic                 reg_write;
        logic                 mem_write;
        logic                 branch;
        logic                 jump;
        logic [1:0]           result_src;
    } idex_t;

    idex_t idex_d;
    idex_t idex_q;

    logic [XLEN-1:0] src_a;
    logic [XLEN-1:0] fwd_b;
    logic [XLEN-1:0] src_b;
    logic [XLEN-1:0] alu_result;

    // Bundle the decode-stage inputs into the register payload
    always_comb begin
        idex_d             = '0;
        idex_d.valid       = id_valid;
        idex_d.alu_control = id_alu_control;
        idex_d.alu_src     = id_alu_src;
        idex_d.rd1         = id_rd1;
        idex_d.rd2         = id_rd2;
        idex_d.imm_ext     = id_imm_ext;
        idex_d.pc          = id_pc;
        idex_d.pc_plus4    = id_pc_plus4;
        idex_d.rs1         = id_rs1;
        idex_d.rs2         = id_rs2;
        idex_d.rd          = id_rd;
        idex_d.reg_write   = id_reg_write;
        idex_d.mem_write   = id_mem_write;
        idex_d.branch      = id_branch;
        idex_d.jump        = id_jump;
        idex_d.result_src  = id_result_src;
    end

    // ID/EX register: flush inserts a bubble and beats stall
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idex_q <= '0;
        end else if (flush_i) begin
            idex_q <= '0;
        end else if (!stall_i) begin
            idex_q <= idex_d;
        end
    end

    // Forwarding muxes; 11 is reserved and falls back to the register value
    always_comb begin
        src_a = idex_q.rd1;
        fwd_b = idex_q.rd2;
        case (forward_a)
            2'b01:   src_a = wb_result;
            2'b10:   src_a = mem_alu_result;
            default: src_a = idex_q.rd1;
        endcase
        case (forward_b)
            2'b01:   fwd_b = wb_result;
            2'b10:   fwd_b = mem_alu_result;
            default: fwd_b = idex_q.rd2;
        endcase
        src_b = idex_q.alu_src ? idex_q.imm_ext : fwd_b;
    end

    // ALU; unused control codes execute as ADD
    always_comb begin
        alu_result = src_a + src_b;
        case (idex_q.alu_control)
            3'b001:  alu_result = src_a - src_b;
            3'b010:  alu_result = src_a & src_b;
            3'b011:  alu_result = src_a | src_b;
            3'b101:  alu_result = XLEN'($signed(src_a) < $signed(src_b));
            default: alu_result = src_a + src_b;
        endcase
    end

    assign ex_valid      = idex_q.valid;
    assign ex_alu_result = alu_result;
    assign ex_write_data = fwd_b;
    assign ex_zero       = (alu_result == '0);
    assign ex_rs1        = idex_q.rs1;
    assign ex_rs2        = idex_q.rs2;
    assign ex_rd         = idex_q.rd;
    assign ex_reg_write  = idex_q.valid & idex_q.reg_write;
    assign ex_mem_write  = idex_q.valid & idex_q.mem_write;
    assign ex_result_src = idex_q.result_src;
    assign ex_pc_target  = idex_q.pc + idex_q.imm_ext;
    assign ex_pc_plus4   = idex_q.pc_plus4;
    assign ex_pc_src     = idex_q.valid & (idex_q.jump | (idex_q.branch & ex_zero));

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the 5-stage RISC-V pipeline, directly downstream of the ALU decoder.
- Holds the ID/EX pipeline register: the decoded 3-bit ALU control, operands, immediate, PC and control bits.
- Applies hazard-unit forwarding muxes, performs the ALU operation and resolves branch/jump redirection.
- Drives the EX/MEM boundary and the fetch-stage PC select.

Parameters:
XLEN, 32, datapath width in bits.

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
stall_i  in  1  hold ID/EX register contents
flush_i  in  1  replace ID/EX contents with bubble
id_valid  in  1  decode stage holds a real instruction
id_alu_control  in  3  ALU control from decoder
id_alu_src  in  1  0: SrcB=rd2 path, 1: SrcB=immediate
id_rd1  in  XLEN  register file read data 1
id_rd2  in  XLEN  register file read data 2
id_imm_ext  in  XLEN  sign-extended immediate
id_pc  in  XLEN  instruction PC
id_pc_plus4  in  XLEN  PC+4
id_rs1, id_rs2, id_rd  in  5  register indices
id_reg_write, id_mem_write, id_branch, id_jump  in  1  control bits
id_result_src  in  2  writeback select
forward_a, forward_b  in  2  forwarding select from hazard unit
mem_alu_result  in  XLEN  EX/MEM ALU result (forward source)
wb_result  in  XLEN  MEM/WB writeback value (forward source)
ex_valid  out  1  EX holds a real instruction
ex_alu_result  out  XLEN  ALU output
ex_write_data  out  XLEN  forwarded rd2 for stores
ex_zero  out  1  ALU result equals zero
ex_rs1, ex_rs2, ex_rd  out  5  registered indices (hazard unit)
ex_reg_write, ex_mem_write  out  1  control bits, gated by ex_valid
ex_result_src  out  2  registered writeback select
ex_pc_src  out  1  redirect fetch to ex_pc_target
ex_pc_target  out  XLEN  ex PC + ex immediate
ex_pc_plus4  out  XLEN  registered PC+4

Behaviour:
- Reset (rst_n low, asynchronous): every ID/EX register field clears to 0.
  - Resulting outputs: ex_valid=0, ex_alu_result=0, ex_zero=1, ex_pc_src=0, ex_pc_target=0; all control outputs 0.
- Register update on each rising clk, priority order:
  - flush_i=1: all fields cleared to 0 (bubble). Flush overrides stall.
  - else stall_i=1: all fields hold their current values.
  - else: all id_* inputs are captured.
- Latency: one cycle from id_* inputs to ex_* outputs. Everything after the register is combinational.
- Forwarding mux, forward_a selects SrcA:
  - 00: registered rd1
  - 01: wb_result
  - 10: mem_alu_result
  - 11: registered rd1 (reserved encoding)
- forward_b selects the rd2 path with the same encoding.
  - ex_write_data = forwarded rd2 path.
  - SrcB = registered immediate if alu_src=1, else forwarded rd2 path.
- ALU control encoding, all arithmetic modulo 2^XLEN:
  - 000 ADD: SrcA+SrcB
  - 001 SUB: SrcA-SrcB
  - 010 AND
  - 011 OR
  - 101 SLT: signed compare, result 1 or 0 zero-extended
  - 100, 110, 111: ADD
- ex_zero = (ex_alu_result == 0).
- ex_pc_target = registered PC + registered immediate, carry discarded.
- ex_pc_src = ex_valid & (jump | (branch & ex_zero)).
- ex_reg_write and ex_mem_write are forced to 0 whenever ex_valid=0.
- Simultaneous events:
  - flush_i and stall_i both high: flush wins.
  - Reset asserted mid-stall: registers clear immediately; the held instruction is lost.
- No internal handling of load-use hazards. The hazard unit drives stall_i/flush_i.

Test Plan:
- Reset: rst_n low mid-cycle -> outputs clear immediately: ex_valid=0, ex_zero=1, ex_pc_src=0, ex_reg_write=0.
- SUB and SLT:
  - id_alu_control=001, rd1=5, rd2=7, alu_src=0 -> next cycle ex_alu_result=0xFFFFFFFE, ex_zero=0.
  - id_alu_control=101, rd1=0xFFFFFFFF, rd2=1 -> ex_alu_result=1.
- Forwarding:
  - forward_a=10, mem_alu_result=0x10, rd1=0x99, id_alu_control=000, imm=4, alu_src=1 -> ex_alu_result=0x14.
  - forward_b=01, wb_result=0xAB -> ex_write_data=0xAB.
- Branch taken:
  - branch=1, SUB rd1=rd2=3, pc=0x100, imm=0x20, id_valid=1 -> ex_zero=1, ex_pc_src=1, ex_pc_target=0x120.
  - Same with id_valid=0 -> ex_pc_src=0.
- Stall then flush: capture instr A; stall_i=1 for 2 cycles with new inputs B -> outputs still A. Then flush_i=1 together with stall_i=1 -> ex_valid=0, ex_reg_write=0, ex_mem_write=0.
- Wrap and reserved codes:
  - ADD 0xFFFFFFFF+1 -> ex_alu_result=0, ex_zero=1.
  - id_alu_control=111 with 2 and 3 -> ex_alu_result=5.
